// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed seven-segment display controller.
// Latches a value on load_i and scans it across up to eight digits with
// leading-zero blanking, per-digit decimal points and overflow dashes.
// Optional feature macro: SSD_BCD_EN selects a sequential double-dabble
// BCD converter; without it the value is shown in hex and busy_o is 0.
module ssd_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned VALUE_W    = 16,
    parameter int unsigned SCAN_DIV   = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VALUE_W-1:0]    value_i,
    input  logic                  load_i,
    input  logic [NUM_DIGITS-1:0] dp_mask_i,
    input  logic                  blank_lz_i,
    output logic                  busy_o,
    output logic [7:0]            an_o,
    output logic [7:0]            cath_o
);

    localparam int unsigned DISP_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W  = 3;

    logic [DISP_W-1:0]   disp_q;
    logic                ovf_q;
    logic [SCAN_DIV-1:0] presc_q;
    logic [IDX_W-1:0]    idx_q;
    logic                wrap;
    logic [7:0]          an_d;
    logic [7:0]          cath_d;

    // Active-low abcdefg pattern for one hex nibble.
    function automatic logic [6:0] seg_dec(input logic [3:0] nib);
        case (nib)
            4'h0: seg_dec = 7'h01;
            4'h1: seg_dec = 7'h4F;
            4'h2: seg_dec = 7'h12;
            4'h3: seg_dec = 7'h06;
            4'h4: seg_dec = 7'h4C;
            4'h5: seg_dec = 7'h24;
            4'h6: seg_dec = 7'h20;
            4'h7: seg_dec = 7'h0F;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h04;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h60;
            4'hC: seg_dec = 7'h31;
            4'hD: seg_dec = 7'h42;
            4'hE: seg_dec = 7'h30;
            default: seg_dec = 7'h38;
        endcase
    endfunction

`ifdef SSD_BCD_EN
    // Accumulator holds every decimal digit of the largest VALUE_W input.
    localparam int unsigned BCD_DIG = VALUE_W / 3 + 1;
    localparam int unsigned ACC_DIG = (BCD_DIG > NUM_DIGITS) ? BCD_DIG : NUM_DIGITS;
    localparam int unsigned ACC_W   = 4 * ACC_DIG;
    localparam int unsigned CNT_W   = $clog2(VALUE_W + 1);

    typedef enum logic {ST_IDLE, ST_CONV} state_t;

    state_t             state_q, state_d;
    logic [VALUE_W-1:0] sh_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_step;
    logic [CNT_W-1:0]   cnt_q;
    logic               acc_ovf;
    logic               start;
    logic               last;

    // One double-dabble iteration plus overflow detection on its result.
    always_comb begin
        logic [ACC_W-1:0] adj;
        adj = acc_q;
        for (int d = 0; d < int'(ACC_DIG); d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
        end
        acc_step = ACC_W'({adj, sh_q[VALUE_W-1]});
        acc_ovf  = 1'b0;
        for (int d = int'(NUM_DIGITS); d < int'(ACC_DIG); d++) begin
            acc_ovf = acc_ovf | (|acc_step[4*d +: 4]);
        end
    end

    // Converter next-state logic.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: if (load_i) begin
                start   = 1'b1;
                state_d = ST_CONV;
            end
            ST_CONV: if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                last    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Converter state register and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d == ST_CONV);
        end
    end

    // Converter datapath; display register commits only on the final iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (start) begin
                sh_q  <= value_i;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state_q == ST_CONV) begin
                sh_q  <= {sh_q[VALUE_W-2:0], 1'b0};
                acc_q <= acc_step;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (last) begin
                disp_q <= acc_step[DISP_W-1:0];
                ovf_q  <= acc_ovf;
            end
        end
    end
`else
    logic hex_ovf;

    // Any input bit beyond the displayable nibbles flags overflow.
    always_comb begin
        hex_ovf = 1'b0;
        for (int i = int'(DISP_W); i < int'(VALUE_W); i++) begin
            hex_ovf = hex_ovf | value_i[i];
        end
    end

    // Hex display register loads directly on the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (load_i) begin
            disp_q <= DISP_W'(value_i);
            ovf_q  <= hex_ovf;
        end
    end

    assign busy_o = 1'b0;
`endif

    assign wrap = &presc_q;

    // Pattern for the digit currently selected by idx_q.
    always_comb begin
        logic [31:0] disp_pad;
        logic [7:0]  dp_pad;
        logic [3:0]  nib;
        logic        upper_nz;
        logic [6:0]  seg;
        disp_pad = 32'(disp_q);
        dp_pad   = 8'(dp_mask_i);
        nib      = disp_pad[{idx_q, 2'b00} +: 4];
        upper_nz = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (IDX_W'(k) >= idx_q && disp_pad[4*k +: 4] != 4'h0) upper_nz = 1'b1;
        end
        if (ovf_q)                                         seg = 7'h7E;
        else if (blank_lz_i && idx_q != '0 && !upper_nz)   seg = 7'h7F;
        else                                               seg = seg_dec(nib);
        cath_d = {seg, ~dp_pad[idx_q]};
        an_d   = ~(8'b1 << idx_q);
    end

    // Prescaler, digit index and registered pin drive, refreshed at each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_o    <= 8'hFF;
            cath_o  <= 8'hFF;
        end else begin
            presc_q <= presc_q + SCAN_DIV'(1);
            if (wrap) begin
                idx_q  <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                an_o   <= an_d;
                cath_o <= cath_d;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Testbench for ssd_scan_ctrl: randomized and directed loads checked
// against a decimal/hex digit model (base chosen by SSD_BCD_EN).
module tb_ssd_scan_ctrl;

    localparam int ND    = 4;
    localparam int VW    = 18;
    localparam int SD    = 2;
    localparam int DWELL = 1 << SD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [VW-1:0] value;
    logic          load;
    logic [ND-1:0] dp;
    logic          blank;
    logic          busy;
    logic [7:0]    an;
    logic [7:0]    cath;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    ssd_scan_ctrl #(.NUM_DIGITS(ND), .VALUE_W(VW), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load),
        .dp_mask_i(dp), .blank_lz_i(blank), .busy_o(busy), .an_o(an), .cath_o(cath)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Expected cathode byte for digit k showing value v.
    function automatic logic [7:0] exp_cath(input longint v, input int k,
                                            input logic [ND-1:0] m, input logic bl);
        longint base, lim, pk, disp, dig;
        logic [6:0] s;
`ifdef SSD_BCD_EN
        base = 10;
`else
        base = 16;
`endif
        lim = 1;
        for (int i = 0; i < ND; i++) lim = lim * base;
        pk = 1;
        for (int i = 0; i < k; i++) pk = pk * base;
        disp = v % lim;
        dig  = (disp / pk) % base;
        if (v >= lim)                      s = 7'h7E;
        else if (bl && k != 0 && disp < pk) s = 7'h7F;
        else                               s = seg_tab[4'(dig)];
        return {s, ~m[k]};
    endfunction

    task automatic do_load(input logic [VW-1:0] v);
        int n;
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        total++;
`ifdef SSD_BCD_EN
        if (n !== VW) begin
            bad++;
            $display("FAIL busy_len: got %0d cycles want %0d", n, VW);
        end
`else
        if (n !== 0) begin
            bad++;
            $display("FAIL busy_hex: got %0d busy cycles want 0", n);
        end
`endif
    endtask

    task automatic check_frame(input longint v, input string name);
        int n;
        logic [7:0] ea, ec;
        repeat (DWELL * (ND + 1)) @(negedge clk);
        n = 0;
        while (an !== 8'hFE && n < DWELL * ND * 2) begin
            n++;
            @(negedge clk);
        end
        for (int k = 0; k < ND; k++) begin
            ea = ~(8'd1 << k);
            ec = exp_cath(v, k, dp, blank);
            total++;
            if (an !== ea || cath !== ec) begin
                bad++;
                $display("FAIL %s digit%0d: got an=%h cath=%h want an=%h cath=%h",
                         name, k, an, cath, ea, ec);
            end
            repeat (DWELL) @(negedge clk);
        end
        total++;
        if (an !== 8'hFE) begin
            bad++;
            $display("FAIL %s wrap: got an=%h want an=fe", name, an);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        value = VW'(16'h1234);
        load  = 1'b1;
        dp    = '0;
        blank = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (an !== 8'hFF || cath !== 8'hFF || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got an=%h cath=%h busy=%b want ff ff 0", an, cath, busy);
        end
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DWELL - 1) @(negedge clk);
        total++;
        if (an !== 8'hFF || cath !== 8'hFF) begin
            bad++;
            $display("FAIL reset_pre_wrap: got an=%h cath=%h want ff ff", an, cath);
        end
        @(negedge clk);
        total++;
        if (an !== 8'hFE || cath !== 8'h03) begin
            bad++;
            $display("FAIL reset_first_digit: got an=%h cath=%h want fe 03", an, cath);
        end
    endtask

    task automatic test_hex_pattern();
        dp    = 4'b0100;
        blank = 1'b0;
        do_load(VW'(16'hBEEF));
        check_frame(longint'(16'hBEEF), "beef");
    endtask

    task automatic test_bcd_conversion();
        dp    = '0;
        blank = 1'b0;
        do_load(VW'(1234));
        check_frame(1234, "v1234");
    endtask

    task automatic test_blanking();
        dp    = '0;
        blank = 1'b1;
        do_load(VW'(42));
        check_frame(42, "lz_on");
        blank = 1'b0;
        check_frame(42, "lz_off");
        blank = 1'b1;
        do_load(VW'(0));
        check_frame(0, "lz_zero");
    endtask

    task automatic test_overflow();
        dp    = 4'b1001;
        blank = 1'b0;
        do_load(VW'(12345));
        check_frame(12345, "ovf_12345");
        do_load(VW'(9999));
        check_frame(9999, "ovf_9999");
        do_load(VW'(18'h3ABCD));
        check_frame(longint'(18'h3ABCD), "ovf_big");
    endtask

    task automatic test_handshake();
        longint ev;
        int n;
        dp    = '0;
        blank = 1'b0;
        @(negedge clk);
        value = VW'(100);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (3) @(negedge clk);
        value = VW'(7);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
`ifdef SSD_BCD_EN
        ev = 100;
`else
        ev = 7;
`endif
        check_frame(ev, "handshake");
    endtask

    task automatic test_reset_mid_conv();
        dp    = '0;
        blank = 1'b0;
        @(negedge clk);
        value = VW'(4321);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (an !== 8'hFF || cath !== 8'hFF || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got an=%h cath=%h busy=%b want ff ff 0", an, cath, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (VW) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_busy: got %b want 0", busy);
        end
        check_frame(0, "reset_mid_clear");
    endtask

    task automatic test_random();
        logic [VW-1:0] v;
        for (int i = 0; i < 12; i++) begin
            v     = VW'($urandom);
            if (i % 3 == 0) v = VW'($urandom_range(0, 999));
            dp    = ND'($urandom);
            blank = 1'($urandom);
            do_load(v);
            check_frame(longint'(v), "random");
        end
    endtask

    initial begin
        test_reset();
        test_hex_pattern();
        test_bcd_conversion();
        test_blanking();
        test_overflow();
        test_handshake();
        test_reset_mid_conv();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
